// File: rtl/sdf_butterfly_stage_if.sv
// rtl/sdf_butterfly_stage_if.sv - sample stream, shifter and output bundle of an R2SDF butterfly stage
interface sdf_butterfly_stage_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DELAY      = 8
);
    logic                         in_valid;
    logic [DATA_WIDTH-1:0]        data_in_r;
    logic [DATA_WIDTH-1:0]        data_in_i;
    logic [DATA_WIDTH-1:0]        from_mem_r;
    logic [DATA_WIDTH-1:0]        from_mem_i;
    logic [DATA_WIDTH-1:0]        to_mem_r;
    logic [DATA_WIDTH-1:0]        to_mem_i;
    logic [DATA_WIDTH-1:0]        data_out_r;
    logic [DATA_WIDTH-1:0]        data_out_i;
    logic                         out_valid;
    logic                         out_is_diff;
    logic [$clog2(DELAY)-1:0]     tw_idx;

    // Environment side: sample source, shifter model and output sink
    modport master (
        output in_valid, data_in_r, data_in_i, from_mem_r, from_mem_i,
        input  to_mem_r, to_mem_i, data_out_r, data_out_i, out_valid, out_is_diff, tw_idx
    );

    // Butterfly stage side
    modport slave (
        input  in_valid, data_in_r, data_in_i, from_mem_r, from_mem_i,
        output to_mem_r, to_mem_i, data_out_r, data_out_i, out_valid, out_is_diff, tw_idx
    );
endinterface

// File: rtl/sdf_butterfly_stage.sv
// rtl/sdf_butterfly_stage.sv - radix-2 single-path delay-feedback butterfly stage
module sdf_butterfly_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int DELAY      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sdf_butterfly_stage_if.slave bus
);
    localparam int CNT_W = $clog2(2 * DELAY);
    localparam int TW_W  = $clog2(DELAY);
    localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(2 * DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_BFLY,
        S_FLUSH
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;        // phase of the sample expected this cycle, or flush step
    logic                   have_prev;  // shifter holds differences of a completed frame

    logic                   out_valid_q;
    logic                   out_is_diff_q;
    logic [TW_W-1:0]        tw_idx_q;
    logic [DATA_WIDTH-1:0]  data_out_r_q;
    logic [DATA_WIDTH-1:0]  data_out_i_q;

    logic signed [DATA_WIDTH:0] a_r, a_i, b_r, b_i;
    logic signed [DATA_WIDTH:0] sum_r, sum_i, dif_r, dif_i;
    logic [DATA_WIDTH-1:0]      sum_half_r, sum_half_i, dif_half_r, dif_half_i;

    logic                   emit;
    logic                   emit_diff;
    logic [TW_W-1:0]        emit_tw;
    logic [DATA_WIDTH-1:0]  emit_r, emit_i;
    logic [DATA_WIDTH-1:0]  mem_r, mem_i;

    // Butterfly arithmetic one bit wider than the samples, then halved with floor
    always_comb begin
        a_r        = {bus.from_mem_r[DATA_WIDTH-1], bus.from_mem_r};
        a_i        = {bus.from_mem_i[DATA_WIDTH-1], bus.from_mem_i};
        b_r        = {bus.data_in_r[DATA_WIDTH-1], bus.data_in_r};
        b_i        = {bus.data_in_i[DATA_WIDTH-1], bus.data_in_i};
        sum_r      = a_r + b_r;
        sum_i      = a_i + b_i;
        dif_r      = a_r - b_r;
        dif_i      = a_i - b_i;
        sum_half_r = DATA_WIDTH'(sum_r >>> 1);
        sum_half_i = DATA_WIDTH'(sum_i >>> 1);
        dif_half_r = DATA_WIDTH'(dif_r >>> 1);
        dif_half_i = DATA_WIDTH'(dif_i >>> 1);
    end

    // Per-phase routing of the shifter input and of the next output sample
    always_comb begin
        emit      = 1'b0;
        emit_diff = 1'b0;
        emit_tw   = '0;
        emit_r    = '0;
        emit_i    = '0;
        mem_r     = '0;
        mem_i     = '0;
        unique case (state)
            S_IDLE: begin
                // A sample arriving while idle is phase 0 of a new frame
                if (bus.in_valid) begin
                    mem_r = bus.data_in_r;
                    mem_i = bus.data_in_i;
                end
            end
            S_FILL: begin
                if (bus.in_valid) begin
                    mem_r = bus.data_in_r;
                    mem_i = bus.data_in_i;
                end
                // Phase 0 without a sample after a full frame is the first flush step
                if ((bus.in_valid && have_prev) || (!bus.in_valid && cnt == '0)) begin
                    emit      = 1'b1;
                    emit_diff = 1'b1;
                    emit_tw   = cnt[TW_W-1:0];
                    emit_r    = bus.from_mem_r;
                    emit_i    = bus.from_mem_i;
                end
            end
            S_BFLY: begin
                if (bus.in_valid) begin
                    mem_r  = dif_half_r;
                    mem_i  = dif_half_i;
                    emit   = 1'b1;
                    emit_r = sum_half_r;
                    emit_i = sum_half_i;
                end
            end
            S_FLUSH: begin
                emit      = 1'b1;
                emit_diff = 1'b1;
                emit_tw   = cnt[TW_W-1:0];
                emit_r    = bus.from_mem_r;
                emit_i    = bus.from_mem_i;
            end
            default: ;
        endcase
    end

    // Phase sequencing and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            have_prev     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_is_diff_q <= 1'b0;
            tw_idx_q      <= '0;
            data_out_r_q  <= '0;
            data_out_i_q  <= '0;
        end else begin
            out_valid_q   <= emit;
            out_is_diff_q <= emit_diff;
            tw_idx_q      <= emit_tw;
            data_out_r_q  <= emit_r;
            data_out_i_q  <= emit_i;
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        state     <= (LAST_FILL == '0) ? S_BFLY : S_FILL;
                        cnt       <= CNT_W'(1);
                        have_prev <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (bus.in_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_FILL) begin
                            state <= S_BFLY;
                        end
                    end else if (cnt == '0) begin
                        state <= S_FLUSH;
                        cnt   <= CNT_W'(1);
                    end else begin
                        // Gap inside a frame: drop the frame and anything still pending
                        state     <= S_IDLE;
                        cnt       <= '0;
                        have_prev <= 1'b0;
                    end
                end
                S_BFLY: begin
                    if (bus.in_valid) begin
                        if (cnt == LAST_CNT) begin
                            state     <= S_FILL;
                            cnt       <= '0;
                            have_prev <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        have_prev <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (cnt == LAST_FILL) begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        have_prev <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.to_mem_r    = rst ? mem_r : '0;
    assign bus.to_mem_i    = rst ? mem_i : '0;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_is_diff = out_is_diff_q;
    assign bus.tw_idx      = tw_idx_q;
    assign bus.data_out_r  = data_out_r_q;
    assign bus.data_out_i  = data_out_i_q;
endmodule

// File: doc/sdf_butterfly_stage.md
# sdf_butterfly_stage

- Radix-2 single-path delay-feedback (R2SDF) butterfly stage for the 128-point SDF IFFT datapath.
- Consumes a continuous complex sample stream and pairs each sample with the sample DELAY positions later.
- Runs the butterfly through an external `Memory_Shifter` (MEMORY_DEPTH = DELAY) that this block both feeds and reads back.
- Emits, per frame, DELAY scaled sums followed by DELAY scaled differences; each difference is tagged with a twiddle index for the downstream twiddle multiplier.

## Interface
- DATA_WIDTH, 16, width of each real/imag component, two's complement
- DELAY, 8, butterfly span; must equal the attached shifter's MEMORY_DEPTH; power of two, ≥ 2
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  sample present on data_in this cycle
- data_in_r, data_in_i  in  DATA_WIDTH  input sample
- from_mem_r, from_mem_i  in  DATA_WIDTH  shifter output
- to_mem_r, to_mem_i  out  DATA_WIDTH  shifter input (combinational)
- data_out_r, data_out_i  out  DATA_WIDTH  stage output (registered)
- out_valid  out  1  data_out holds a valid sample
- out_is_diff  out  1  data_out is a difference term
- tw_idx  out  $clog2(DELAY)  twiddle index for the difference term; 0 for sums

## Operation
- **Phase counter** `cnt`, 0..2·DELAY−1. States: IDLE, FILL (cnt < DELAY), BFLY (cnt ≥ DELAY), FLUSH.
- **IDLE**
  - to_mem = 0; out_valid = 0.
  - in_valid=1 → consume the sample as cnt=0; go to FILL.
- **FILL**
  - to_mem = data_in.
  - If a previous frame exists, output from_mem as a difference: out_is_diff=1, tw_idx = cnt.
  - Otherwise output nothing (out_valid=0).
- **BFLY**
  - a = from_mem, b = data_in.
  - Output s = (a+b)>>>1, with out_is_diff=0 and tw_idx=0.
  - to_mem = d = (a−b)>>>1.
- **Arithmetic**
  - Sum and difference computed at DATA_WIDTH+1 bits per component.
  - Arithmetic shift right by 1, i.e. floor; no rounding, no saturation.
  - Result cannot overflow DATA_WIDTH.
- **End of frame** (cnt = 2·DELAY−1 consumed)
  - in_valid=1 next cycle → cnt wraps to 0, stay in FILL (back-to-back frames).
  - in_valid=0 → go to FLUSH.
- **FLUSH**, DELAY cycles
  - to_mem = 0.
  - Output from_mem as differences with tw_idx = flush count.
  - Then go to IDLE.
  - in_valid=1 during FLUSH is ignored (sample dropped). Upstream must not start a new frame until FLUSH completes.
- **Mid-frame abort** (in_valid=0 while cnt ≠ 0 in FILL/BFLY)
  - Abort the frame: go to IDLE, cnt=0, drop out_valid next cycle.
  - Pending differences are discarded.
  - The shifter contents are stale and are overwritten by the next frame's FILL.
- Input stream must be gap-free within a frame, because the shifter advances every clock.

## Timing
- **Reset (rst=0)**
  - State IDLE, cnt=0.
  - data_out_r/i=0, out_valid=0, out_is_diff=0, tw_idx=0.
  - to_mem=0 while in reset.
- Reset mid-frame clears everything immediately; nothing further is output.
- **Latency**
  - First sum appears DELAY+1 cycles after the first sample of a frame.
  - Difference k appears 2·DELAY+1+k cycles after the first sample.
- Back-to-back frames give continuous out_valid=1 after the first DELAY+1 cycles.
- to_mem is combinational from data_in/from_mem in the same cycle; no registers between this block and the shifter input.

## Test plan
1. **Reset**
   - Stimulus: rst=0 with random inputs, then release.
   - Required: all outputs 0 and to_mem=0 throughout.
2. **Single frame, DELAY=2**
   - Stimulus: real inputs 4,8,2,6 (imag 0) at cycles 0–3, then in_valid=0.
   - Required: out 3 @cycle 3, 7 @4 (sums); 1 @5 tw 0, 1 @6 tw 1 (diffs, out_is_diff=1); out_valid=0 from cycle 7; state IDLE.
3. **Floor and full-scale, DATA_WIDTH=16**
   - Pair a=1, b=−4 → sum −2, diff 2.
   - Pair a=32767, b=32767 → sum 32767, diff 0.
   - Pair a=−32768, b=32767 → sum −1, diff −32768.
   - Same checks on the imag path.
4. **Back-to-back frames, DELAY=8**
   - Stimulus: three consecutive ramp frames.
   - Required: out_valid continuous from cycle 9 to the end of flush; sums/diffs match a golden model; tw_idx cycles 0..7.
5. **Mid-frame abort**
   - Stimulus: in_valid drops at cnt=5; a fresh frame starts 2 cycles later.
   - Required: out_valid=0 one cycle after the drop; no stale differences emitted; the new frame's outputs are exact.
6. **Reset mid-FLUSH**
   - Stimulus: rst=0 asserted during the second flush cycle.
   - Required: outputs zero asynchronously; a frame after release behaves as in scenario 2.
